// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Receive side of the 640x480@60 VGA timing driver. Samples hsync/vsync and
//   4-bit R/G/B on pixel-strobe cycles, re-derives the horizontal/vertical
//   counters from the sync edges, locks after LOCK_FRAMES clean frames and
//   then emits one coordinate-tagged pixel per active position.
//
// Ports
//   clock        system clock (only clock)
//   rst          synchronous active-high reset
//   pix_en       one-cycle pixel strobe; nothing changes on cycles without it
//   hsync/vsync  active-low syncs
//   disp_r/g/b   4-bit colour components
//   cap_rgb      captured pixel {b,g,r}, held between pulses
//   cap_x/cap_y  active column/row of the captured pixel, held between pulses
//   cap_valid    one-cycle pulse, cap_* updated
//   frame_start  one-cycle pulse per detected vsync falling edge
//   locked       high while the lock FSM is in LOCKED
//   err_hline    one-cycle pulse, horizontal timing error
//   err_vframe   one-cycle pulse, vertical timing error
//   err_sticky   set by any error, cleared only by rst
//   frame_sum    (VGA_CHECKSUM_EN only) 16-bit sum of cap_rgb over the last
//                frame completed while locked
//
// Build option
//   VGA_CHECKSUM_EN  adds the frame_sum output and its accumulator.

module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_BEGIN = 144,
  parameter int H_ACT       = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_BEGIN = 35,
  parameter int V_ACT       = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  disp_r,
  input  logic [3:0]  disp_g,
  input  logic [3:0]  disp_b,
  output logic [11:0] cap_rgb,
  output logic [9:0]  cap_x,
  output logic [9:0]  cap_y,
  output logic        cap_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        err_hline,
  output logic        err_vframe,
`ifdef VGA_CHECKSUM_EN
  output logic [15:0] frame_sum,
`endif
  output logic        err_sticky
);

  localparam logic [9:0] C_SAT       = 10'h3FF;
  localparam logic [9:0] C_H_TOTAL   = 10'(H_TOTAL);
  localparam logic [9:0] C_H_SYNC_M1 = 10'(H_SYNC - 1);
  localparam logic [9:0] C_H_ACT_LO  = 10'(H_ACT_BEGIN);
  localparam logic [9:0] C_H_ACT_HI  = 10'(H_ACT_BEGIN + H_ACT);
  localparam logic [9:0] C_V_TOTAL   = 10'(V_TOTAL);
  localparam logic [9:0] C_V_SYNC    = 10'(V_SYNC);
  localparam logic [9:0] C_V_ACT_LO  = 10'(V_ACT_BEGIN);
  localparam logic [9:0] C_V_ACT_HI  = 10'(V_ACT_BEGIN + V_ACT);
  localparam logic [7:0] C_LOCK      = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_hs_prev;
  logic        r_vs_prev;     // vsync as seen at the previous line start
  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic        r_h_ovf;       // missing-hsync already reported for this line
  logic        r_v_ovf;       // missing-vsync already reported for this frame
  logic [7:0]  r_good_cnt;
  logic        r_frame_err;   // current frame has seen an error

  logic        w_h_fall;
  logic        w_h_rise;
  logic        w_v_fall;
  logic        w_v_rise;
  logic [9:0]  w_h_inc;
  logic [9:0]  w_v_inc;
  logic [9:0]  w_h_next;
  logic [9:0]  w_v_next;
  logic        w_h_ovf_hit;
  logic        w_v_ovf_hit;
  logic        w_h_err_raw;
  logic        w_v_err_raw;
  logic        w_report;
  logic        w_err_h;
  logic        w_err_v;
  logic        w_err_any;
  logic        w_in_act;
  logic        w_cap;
  logic [7:0]  w_good_inc;

  always_comb begin
    w_h_fall = r_hs_prev & ~hsync;
    w_h_rise = ~r_hs_prev & hsync;
    // vsync is only looked at on line starts, against the previous line start
    w_v_fall = w_h_fall & r_vs_prev & ~vsync;
    w_v_rise = w_h_fall & ~r_vs_prev & vsync;

    w_h_inc  = (r_h_cnt == C_SAT) ? C_SAT : r_h_cnt + 10'd1;
    w_v_inc  = (r_v_cnt == C_SAT) ? C_SAT : r_v_cnt + 10'd1;
    w_h_next = w_h_fall ? 10'd0 : w_h_inc;
    w_v_next = w_v_fall ? 10'd0 : (w_h_fall ? w_v_inc : r_v_cnt);

    // Overrun fires once when the count has already reached the total without
    // a sync edge; saturation keeps it from matching again.
    w_h_ovf_hit = ~w_h_fall & (r_h_cnt == C_H_TOTAL);
    w_v_ovf_hit = w_h_fall & ~w_v_fall & (r_v_cnt == C_V_TOTAL);

    // An edge that ends an already-reported overrun is not reported again.
    w_h_err_raw = (w_h_fall & ~r_h_ovf & (w_h_inc != C_H_TOTAL))
                | (w_h_rise & (r_h_cnt != C_H_SYNC_M1))
                | w_h_ovf_hit;
    w_v_err_raw = (w_v_fall & ~r_v_ovf & (w_v_inc != C_V_TOTAL))
                | (w_v_rise & (w_v_next != C_V_SYNC))
                | w_v_ovf_hit;

    w_report  = (r_state != ST_SEARCH);
    w_err_h   = pix_en & w_report & w_h_err_raw;
    w_err_v   = pix_en & w_report & w_v_err_raw;
    w_err_any = w_err_h | w_err_v;

    w_in_act = (w_h_next >= C_H_ACT_LO) && (w_h_next < C_H_ACT_HI) &&
               (w_v_next >= C_V_ACT_LO) && (w_v_next < C_V_ACT_HI);
    // An error drops lock on the same sample, so that sample is not captured.
    w_cap    = pix_en & (r_state == ST_LOCKED) & ~w_err_any & w_in_act;

    w_good_inc = (r_good_cnt == 8'hFF) ? r_good_cnt : r_good_cnt + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state     <= ST_SEARCH;
      r_hs_prev   <= 1'b1;
      r_vs_prev   <= 1'b1;
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_h_ovf     <= 1'b0;
      r_v_ovf     <= 1'b0;
      r_good_cnt  <= '0;
      r_frame_err <= 1'b0;
      cap_rgb     <= '0;
      cap_x       <= '0;
      cap_y       <= '0;
      cap_valid   <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err_hline   <= 1'b0;
      err_vframe  <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      cap_valid   <= 1'b0;
      frame_start <= 1'b0;
      err_hline   <= 1'b0;
      err_vframe  <= 1'b0;
      if (pix_en) begin
        r_hs_prev <= hsync;
        if (w_h_fall) r_vs_prev <= vsync;
        r_h_cnt <= w_h_next;
        r_v_cnt <= w_v_next;

        if (w_h_fall)         r_h_ovf <= 1'b0;
        else if (w_h_ovf_hit) r_h_ovf <= 1'b1;
        if (w_v_fall)         r_v_ovf <= 1'b0;
        else if (w_v_ovf_hit) r_v_ovf <= 1'b1;

        frame_start <= w_v_fall;
        err_hline   <= w_err_h;
        err_vframe  <= w_err_v;
        if (w_err_any) err_sticky <= 1'b1;

        if (w_cap) begin
          cap_valid <= 1'b1;
          cap_x     <= w_h_next - C_H_ACT_LO;
          cap_y     <= w_v_next - C_V_ACT_LO;
          cap_rgb   <= {disp_b, disp_g, disp_r};
        end

        unique case (r_state)
          ST_SEARCH: begin
            locked <= 1'b0;
            if (w_v_fall) begin
              r_state     <= ST_TRAIN;
              r_good_cnt  <= '0;
              r_frame_err <= 1'b0;
            end
          end
          ST_TRAIN: begin
            locked <= 1'b0;
            if (w_v_fall) begin
              // an error on the frame_start sample belongs to the old frame
              r_frame_err <= 1'b0;
              if (r_frame_err | w_err_any) begin
                r_good_cnt <= '0;
              end else begin
                r_good_cnt <= w_good_inc;
                if (w_good_inc >= C_LOCK) begin
                  r_state <= ST_LOCKED;
                  locked  <= 1'b1;
                end
              end
            end else if (w_err_any) begin
              r_frame_err <= 1'b1;
            end
          end
          ST_LOCKED: begin
            if (w_err_any) begin
              r_state     <= ST_TRAIN;
              r_good_cnt  <= '0;
              // the interrupted frame counts as bad unless it just ended
              r_frame_err <= ~w_v_fall;
              locked      <= 1'b0;
            end else begin
              locked <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_SEARCH;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef VGA_CHECKSUM_EN
  logic [15:0] r_sum_acc;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_sum_acc <= '0;
      frame_sum <= '0;
    end else if (pix_en) begin
      if (w_v_fall) begin
        r_sum_acc <= '0;
        if ((r_state == ST_LOCKED) && !w_err_any) frame_sum <= r_sum_acc;
      end else if (w_cap) begin
        r_sum_acc <= r_sum_acc + {4'd0, disp_b, disp_g, disp_r};
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a reduced raster (40x20 total).
// The generator emits whole frames with optional injected faults; a
// frame-level lock model decides which samples should be captured and which
// samples should raise frame_start / err_* pulses. A separate monitor pops
// those expectations whenever the DUT pulses an output.

module tb_vga_sync_decoder;

  localparam int H_TOTAL     = 40;
  localparam int H_SYNC      = 4;
  localparam int H_ACT_BEGIN = 8;
  localparam int H_ACT       = 24;
  localparam int V_TOTAL     = 20;
  localparam int V_SYNC      = 2;
  localparam int V_ACT_BEGIN = 4;
  localparam int V_ACT       = 12;
  localparam int LOCK_FRAMES = 2;
  localparam int STUCK_PIX   = 1100;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [3:0]  disp_r = 4'd0;
  logic [3:0]  disp_g = 4'd0;
  logic [3:0]  disp_b = 4'd0;
  logic [11:0] cap_rgb;
  logic [9:0]  cap_x;
  logic [9:0]  cap_y;
  logic        cap_valid;
  logic        frame_start;
  logic        locked;
  logic        err_hline;
  logic        err_vframe;
  logic        err_sticky;

  always #5 clock = ~clock;

  vga_sync_decoder #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_ACT_BEGIN(H_ACT_BEGIN), .H_ACT(H_ACT),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_ACT_BEGIN(V_ACT_BEGIN), .V_ACT(V_ACT),
    .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clock(clock), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .disp_r(disp_r), .disp_g(disp_g), .disp_b(disp_b),
    .cap_rgb(cap_rgb), .cap_x(cap_x), .cap_y(cap_y), .cap_valid(cap_valid),
    .frame_start(frame_start), .locked(locked), .err_hline(err_hline),
    .err_vframe(err_vframe), .err_sticky(err_sticky)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int serial  = 0;     // index of the sample currently driven
  int sampled = -1;    // index of the last sample the DUT took
  int n_caps  = 0;

  always @(posedge clock) if (pix_en) sampled <= serial;

  typedef struct {
    int         ser;
    logic [9:0] x;
    logic [9:0] y;
    logic [11:0] rgb;
  } cap_t;

  cap_t q_cap[$];
  int   q_fs[$];
  int   q_eh[$];
  int   q_ev[$];

  // frame-level lock model
  bit m_search;
  bit m_locked;
  bit m_bad;
  bit m_sticky;
  int m_clean;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor
  always @(negedge clock) begin : mon
    cap_t c;
    int   e;
    if (cap_valid) begin
      n_caps++;
      if (q_cap.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL cap_valid: unexpected capture at sample %0d x=%0d y=%0d", sampled, cap_x, cap_y);
      end else begin
        c = q_cap.pop_front();
        check("cap sample", 64'(sampled), 64'(c.ser));
        check("cap_x", 64'(cap_x), 64'(c.x));
        check("cap_y", 64'(cap_y), 64'(c.y));
        check("cap_rgb", 64'(cap_rgb), 64'(c.rgb));
      end
    end
    if (frame_start) begin
      if (q_fs.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL frame_start: unexpected pulse at sample %0d", sampled);
      end else begin
        e = q_fs.pop_front();
        check("frame_start sample", 64'(sampled), 64'(e));
      end
    end
    if (err_hline) begin
      if (q_eh.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL err_hline: unexpected pulse at sample %0d", sampled);
      end else begin
        e = q_eh.pop_front();
        check("err_hline sample", 64'(sampled), 64'(e));
      end
    end
    if (err_vframe) begin
      if (q_ev.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL err_vframe: unexpected pulse at sample %0d", sampled);
      end else begin
        e = q_ev.pop_front();
        check("err_vframe sample", 64'(sampled), 64'(e));
      end
    end
  end

  task automatic frame_begin();
    q_fs.push_back(serial);
    if (m_search) begin
      m_search = 1'b0;
      m_clean  = 0;
      m_bad    = 1'b0;
      m_locked = 1'b0;
    end else begin
      if (m_bad) m_clean = 0;
      else       m_clean++;
      m_bad = 1'b0;
      if (m_clean >= LOCK_FRAMES) m_locked = 1'b1;
    end
  endtask

  task automatic fault(input bit vert);
    if (!m_search) begin
      if (vert) q_ev.push_back(serial);
      else      q_eh.push_back(serial);
      m_bad    = 1'b1;
      m_locked = 1'b0;
      m_sticky = 1'b1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic send(input logic hs, input logic vs, input logic [3:0] r,
                      input logic [3:0] g, input logic [3:0] b, input int hx, input int vy);
    cap_t c;
    int   k;
    if (m_locked && hx >= H_ACT_BEGIN && hx < H_ACT_BEGIN + H_ACT &&
        vy >= V_ACT_BEGIN && vy < V_ACT_BEGIN + V_ACT) begin
      c.ser = serial;
      c.x   = 10'(hx - H_ACT_BEGIN);
      c.y   = 10'(vy - V_ACT_BEGIN);
      c.rgb = {b, g, r};
      q_cap.push_back(c);
    end
    hsync = hs; vsync = vs; disp_r = r; disp_g = g; disp_b = b;
    pix_en = 1'b1;
    @(posedge clock); #1;
    pix_en = 1'b0;
    check("locked", 64'(locked), 64'(m_locked));
    check("err_sticky", 64'(err_sticky), 64'(m_sticky));
    serial++;
    k = $urandom_range(0, 2);
    repeat (k) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    pix_en = 1'b0;
    @(posedge clock); #1;
    rst = 1'b0;
    check("outputs after reset",
          64'({cap_rgb, cap_x, cap_y, cap_valid, frame_start, locked, err_hline, err_vframe, err_sticky}),
          64'(0));
    m_search = 1'b1;
    m_locked = 1'b0;
    m_bad    = 1'b0;
    m_sticky = 1'b0;
  endtask

  task automatic gen_frame(input int vs_low, input int long_line, input int stuck_line,
                           input int rst_line, input bit pattern);
    for (int ly = 0; ly < V_TOTAL; ly++) begin
      int   len;
      logic vs;
      len = (ly == long_line) ? H_TOTAL + 1 : H_TOTAL;
      vs  = (ly < vs_low) ? 1'b0 : 1'b1;
      for (int px = 0; px < len; px++) begin
        logic [11:0] rnd;
        logic [3:0]  r, g, b;
        if (pattern) begin
          r = px[3:0]; g = px[3:0]; b = px[3:0];
        end else begin
          rnd = 12'($urandom);
          r = rnd[3:0]; g = rnd[7:4]; b = rnd[11:8];
        end
        if (ly == rst_line && px == 10) apply_reset();
        if (ly == 0 && px == 0) frame_begin();
        if (px == 0 && ly == long_line + 1) fault(1'b0);
        if (px == 0 && ly == vs_low && vs_low != V_SYNC) fault(1'b1);
        send((px < H_SYNC) ? 1'b0 : 1'b1, vs, r, g, b, px, ly);
      end
      if (ly == stuck_line) begin
        for (int k = 0; k < STUCK_PIX; k++) begin
          logic [11:0] rs;
          rs = 12'($urandom);
          if (k == 1) fault(1'b0);
          send(1'b1, vs, rs[3:0], rs[7:4], rs[11:8], -1, -1);
        end
      end
    end
  endtask

  task automatic drain();
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    int caps0;
    m_search = 1'b1; m_locked = 1'b0; m_bad = 1'b0; m_sticky = 1'b0; m_clean = 0;
    repeat (3) @(posedge clock);
    #1;
    rst = 1'b0;
    check("outputs after reset",
          64'({cap_rgb, cap_x, cap_y, cap_valid, frame_start, locked, err_hline, err_vframe, err_sticky}),
          64'(0));

    // acquire lock: two clean frames after the first frame_start
    gen_frame(V_SYNC, -10, -1, -1, 1'b0);
    gen_frame(V_SYNC, -10, -1, -1, 1'b0);
    caps0 = n_caps;
    gen_frame(V_SYNC, -10, -1, -1, 1'b1);
    drain();
    check("captures in locked frame", 64'(n_caps - caps0), 64'(H_ACT * V_ACT));

    // one line one pixel too long, then relock
    gen_frame(V_SYNC, 5, -1, -1, 1'b0);
    gen_frame(V_SYNC, -10, -1, -1, 1'b0);
    gen_frame(V_SYNC, -10, -1, -1, 1'b0);

    // vsync low one line too long, then relock
    gen_frame(V_SYNC, -10, -1, -1, 1'b0);
    gen_frame(V_SYNC + 1, -10, -1, -1, 1'b0);
    gen_frame(V_SYNC, -10, -1, -1, 1'b0);
    gen_frame(V_SYNC, -10, -1, -1, 1'b0);

    // hsync stuck high, then relock
    gen_frame(V_SYNC, -10, 5, -1, 1'b0);
    gen_frame(V_SYNC, -10, -1, -1, 1'b0);
    gen_frame(V_SYNC, -10, -1, -1, 1'b0);

    // reset mid-frame, then search/train/lock again
    gen_frame(V_SYNC, -10, -1, 8, 1'b0);
    gen_frame(V_SYNC, -10, -1, -1, 1'b0);
    gen_frame(V_SYNC, -10, -1, -1, 1'b0);
    caps0 = n_caps;
    gen_frame(V_SYNC, -10, -1, -1, 1'b0);
    drain();
    check("captures after relock", 64'(n_caps - caps0), 64'(H_ACT * V_ACT));

    check("pending captures", 64'(q_cap.size()), 64'(0));
    check("pending frame_start", 64'(q_fs.size()), 64'(0));
    check("pending err_hline", 64'(q_eh.size()), 64'(0));
    check("pending err_vframe", 64'(q_ev.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached (tests=%0d)", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA timing driver: samples hsync/vsync and 4-bit R/G/B and recovers the 640x480@60 raster.
- Locks to the incoming timing and re-derives pixel coordinates.
- Emits one coordinate-tagged pixel per active pixel, with framing and timing-error indications.
- Sits in loopback/self-check paths and capture logic in the breakout display chain.

Parameters:
- H_TOTAL, 800, pixels per line
- H_SYNC, 96, hsync low width in pixels
- H_ACT_BEGIN, 144, h count of first active pixel
- H_ACT, 640, active pixels per line
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, vsync low width in lines
- V_ACT_BEGIN, 35, v count of first active line
- V_ACT, 480, active lines per frame
- LOCK_FRAMES, 2, consecutive error-free frames needed to lock

Ports:
- clock  in  1  system clock; the only clock
- rst  in  1  synchronous active-high reset
- pix_en  in  1  one-cycle pixel strobe; all sampling and counting happens only on cycles with pix_en=1
- hsync  in  1  line sync, active low
- vsync  in  1  frame sync, active low
- disp_r  in  4  red
- disp_g  in  4  green
- disp_b  in  4  blue
- cap_rgb  out  12  captured pixel, packed {b,g,r}
- cap_x  out  10  active column, 0..639
- cap_y  out  10  active row, 0..479
- cap_valid  out  1  one-cycle pulse, cap_* valid
- frame_start  out  1  one-cycle pulse at each detected vsync falling edge
- locked  out  1  high while in LOCKED
- err_hline  out  1  one-cycle pulse, horizontal timing error
- err_vframe  out  1  one-cycle pulse, vertical timing error
- err_sticky  out  1  set by any error; cleared only by rst

Behaviour:
- Reset: every output 0; h_cnt=0, v_cnt=0, good_cnt=0, state=SEARCH, previous-sync registers=1.
- Sampling: on each pix_en cycle, register hsync/vsync/rgb; edges are detected against the previous pix_en sample.
- Line start is the hsync falling edge (prev=1, cur=0). At line start:
  - h_cnt<=0.
  - If h_cnt+1 != H_TOTAL and not in SEARCH: err_hline pulse.
  - Otherwise h_cnt increments, saturating at 1023.
- At the hsync rising edge, h_cnt (before increment) must equal H_SYNC-1; otherwise err_hline.
- If h_cnt reaches H_TOTAL with no falling edge: err_hline once (not repeated while saturated).
- vsync is evaluated only at line starts. A vsync falling edge sets:
  - v_cnt<=0 and frame_start pulse.
  - A frame error if the previous v_cnt+1 != V_TOTAL.
  - Otherwise each line start increments v_cnt (saturating at 1023).
- The vsync rising edge must occur at v_cnt==V_SYNC; otherwise err_vframe.
- Missing vsync by v_cnt==V_TOTAL: err_vframe once.
- FSM:
  - SEARCH: waits for the first vsync falling edge, then goes to TRAIN with good_cnt=0; no errors are reported in SEARCH.
  - TRAIN: at each frame_start, good_cnt++ if the completed frame had no error, else good_cnt=0. When good_cnt reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: any err_hline or err_vframe goes to TRAIN with good_cnt=0, on the same cycle as the error pulse.
- Capture: when locked and H_ACT_BEGIN <= h_cnt < H_ACT_BEGIN+H_ACT and V_ACT_BEGIN <= v_cnt < V_ACT_BEGIN+V_ACT:
  - cap_valid pulses on the clock after the pix_en sample (latency 1 clock).
  - cap_x=h_cnt-H_ACT_BEGIN, cap_y=v_cnt-V_ACT_BEGIN (10-bit truncating subtraction); cap_rgb={disp_b,disp_g,disp_r} of that sample.
  - cap_* hold their value between pulses.
- Simultaneous events:
  - An error and frame_start on the same pix_en: the error counts against the frame just completed.
  - hsync and vsync falling on the same sample: a valid line-0 start.
- rst mid-frame: immediate return to SEARCH; capture resumes only after relock.
- pix_en=0: no state change; pulses deassert.

Optional Feature:
- VGA_CHECKSUM_EN defined:
  - Adds output frame_sum[15:0]: sum mod 2^16 of cap_rgb (zero-extended) over all cap_valid pulses in a frame.
  - Latched at frame_start; the accumulator is cleared at frame_start.
  - Reset value 0; only frames completed while locked update frame_sum.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Nominal 800x525 timing, pix_en every 4th clock, 3 frames:
  - locked rises at the 3rd frame_start (LOCK_FRAMES=2 after SEARCH).
  - Then exactly 307200 cap_valid pulses per frame; first pulse x=0,y=0; last pulse x=639,y=479.
- Pattern rgb = h_cnt[3:0] replicated; check cap_rgb=12'hxxx matches {b,g,r} at x=0 (h=144 -> 12'h000) and x=5 (12'h555), each 1 clock after the sample.
- One line with 801 pixels while locked:
  - single err_hline at that line start; locked falls the same cycle; err_sticky=1.
  - relock after 2 clean frames.
- vsync low for 3 lines:
  - err_vframe at the rising edge (v_cnt=3); no cap_valid until relock.
- hsync stuck high for 1100 pixels:
  - exactly one err_hline at h_cnt=800; h_cnt saturates at 1023; recovery on the next edge.
- rst asserted mid-frame at v=200:
  - all outputs 0 next clock; frame_start only on the next vsync falling edge.
- VGA_CHECKSUM_EN, constant rgb 12'h001:
  - frame_sum = 307200 mod 65536 = 16'hB000 after the first locked frame.
